fetch_issue_queue: RTL
======================

# fetch_issue_queue

Instruction buffer between the fetch unit and the decode stage of the 7-stage stall/bypass pipeline. Captures each returned instruction/PC pair from instruction memory into a small FIFO, then presents a registered instruction to decode. Absorbs decode stalls without dropping in-flight memory responses. Squashes everything on a control-flow redirect.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_BITS, 20, PC width (byte address)
- DEPTH, 4, queue entries; power of two, ≥ 2
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- instruction_fetch  in  DATA_WIDTH  instruction word returned by instruction memory
- inst_PC_fetch  in  ADDRESS_BITS  byte PC of instruction_fetch
- valid_fetch  in  1  instruction_fetch/inst_PC_fetch are a real response this cycle
- stall  in  1  decode cannot accept a new instruction; output register holds
- flush  in  1  redirect (JAL/JALR/branch resolved in execute); squash queue and output
- instruction_decode  out  DATA_WIDTH  registered instruction to decode
- inst_PC_decode  out  ADDRESS_BITS  registered PC to decode
- valid_decode  out  1  instruction_decode is real (0 = bubble)
- fetch_hold  out  1  combinational; fetch must stop issuing reads
- flush_count  out  32  number of flush cycles seen since reset (saturating)

## Operation
- Storage: DEPTH-entry circular buffer of {instruction, PC}; rd_ptr, wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- empty = (count == 0); full = (count == DEPTH).
- enq = valid_fetch & ~full & ~flush. Writes entry at wr_ptr; wr_ptr increments.
- valid_fetch while full: the response is dropped. This is a protocol error because fetch_hold prevents it; it does not corrupt state.
- deq = ~stall & ~empty & ~flush. Output register loads entry at rd_ptr with valid_decode=1; rd_ptr increments.
- ~stall & empty & ~flush: output register loads NOP (32'h00000013), inst_PC_decode holds its value, valid_decode=0.
- stall & ~flush: output register and rd_ptr hold; enqueue still allowed.
- flush (priority over stall, enq, and deq): rd_ptr=wr_ptr=count=0; output register = NOP, valid_decode=0, PC held. The valid_fetch of the same cycle is discarded.
- count update: +1 on enq only, −1 on deq only, unchanged when both or neither occur.
- fetch_hold = (count >= DEPTH-1). This leaves one slot of slack for the response already in flight from memory.
- flush_count increments on each cycle with flush=1 and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: instruction_decode=NOP, inst_PC_decode=0, valid_decode=0, fetch_hold=0, flush_count=0, pointers and count 0.
- Latency: a response enqueued at edge E appears on the outputs after edge E+1 when stall=0 throughout. There is no bypass from input to output.
- Throughput: one instruction per cycle in steady state (simultaneous enq and deq).
- Full with simultaneous deq: enq is still refused because full is evaluated before deq. A full queue with stall=0 frees a slot that can be filled on the following cycle.
- reset asserted mid-operation: all state returns to reset values on the next edge, regardless of flush or stall.

## Structure
- Shared pipeline package: NOP constant (32'h00000013) and the next_PC_select encodings. Flush is generated outside this block from next_PC_select_execute != 0.
- One sub-module: fifo_ram (DEPTH×(DATA_WIDTH+ADDRESS_BITS), one write port, one asynchronous read port).
- Pointer, count, output-register, and counter logic stay in fetch_issue_queue.

## Test plan
- Reset release, no traffic -> instruction_decode=0x00000013, valid_decode=0, fetch_hold=0 for 10 cycles.
- Four responses at PC 0x0,0x4,0x8,0xC on consecutive cycles, stall=0 -> same words appear on consecutive cycles starting one cycle after the first enqueue, each with valid_decode=1, then a NOP bubble.
- stall=1 for 5 cycles while 3 responses arrive -> output holds its previous value; fetch_hold rises when count reaches 3; after stall drops, the 3 instructions drain in order.
- Queue holding 2 entries, flush pulsed together with valid_fetch -> next cycle valid_decode=0, count=0, the flushed and incoming words never appear; flush_count=1.
- DEPTH entries filled, valid_fetch forced high once more -> extra word dropped, count stays 4, the original 4 words drain intact.
- stall=1 and flush=1 in the same cycle -> flush wins: queue empty and output NOP, valid_decode=0.

Source files
------------

// File: rtl/fetch_issue_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
// A nonzero next_PC_select in execute produces the flush into the fetch issue queue.
package fetch_issue_queue_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  typedef enum logic [1:0] {
    NPC_SEQUENTIAL = 2'd0,
    NPC_BRANCH     = 2'd1,
    NPC_JAL        = 2'd2,
    NPC_JALR       = 2'd3
  } next_pc_select_e;

endpackage

// File: rtl/fetch_issue_queue_fifo_ram.sv
// Storage array for the fetch issue queue: one synchronous write port and one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 52
) (
  input  logic                     clock,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [$clog2(DEPTH)-1:0] read_address,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/fetch_issue_queue.sv
// Instruction buffer between fetch and decode: queues memory responses and feeds a
// registered instruction/PC to decode, holding on stall and squashing on redirect.
module fetch_issue_queue
  import fetch_issue_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   instruction_fetch,
  input  logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  input  logic                    valid_fetch,
  input  logic                    stall,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   instruction_decode,
  output logic [ADDRESS_BITS-1:0] inst_PC_decode,
  output logic                    valid_decode,
  output logic                    fetch_hold,
  output logic [31:0]             flush_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + ADDRESS_BITS;

  localparam logic [CNT_W-1:0]      FULL_LEVEL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      HOLD_LEVEL = CNT_W'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_INSTRUCTION);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] rd_entry;

  assign empty = (count == '0);
  assign full  = (count == FULL_LEVEL);
  // Full is judged on the current count, so a simultaneous dequeue does not open a slot this cycle.
  assign enq   = valid_fetch & ~full & ~flush;
  assign deq   = ~stall & ~empty & ~flush;

  // One slot of slack covers the read already in flight when hold is raised.
  assign fetch_hold = (count >= HOLD_LEVEL);

  fifo_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo_ram (
    .clock        (clock),
    .write_enable (enq),
    .write_address(wr_ptr),
    .write_data   ({instruction_fetch, inst_PC_fetch}),
    .read_address (rd_ptr),
    .read_data    (rd_entry)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_decode <= NOP_WORD;
      inst_PC_decode     <= '0;
      valid_decode       <= 1'b0;
    end else if (flush) begin
      instruction_decode <= NOP_WORD;
      valid_decode       <= 1'b0;
    end else if (!stall) begin
      if (!empty) begin
        instruction_decode <= rd_entry[ENTRY_W-1:ADDRESS_BITS];
        inst_PC_decode     <= rd_entry[ADDRESS_BITS-1:0];
        valid_decode       <= 1'b1;
      end else begin
        instruction_decode <= NOP_WORD;
        valid_decode       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_count <= '0;
    end else if (flush && (flush_count != '1)) begin
      flush_count <= flush_count + 1'b1;
    end
  end

endmodule
